// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: per-channel FSM encoding
// and default timing constants for a 100 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

  // 10 ms debounce window and 1 s long-press threshold at 100 MHz.
  localparam int BTN_DEBOUNCE_100MHZ = 1_000_000;
  localparam int BTN_LONG_100MHZ     = 100_000_000;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, polarity fix-up, debounce,
// press/release/long-press pulse generation and a press-toggled latch.
module button_channel
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_100MHZ,
  parameter int LONG_CYCLES     = BTN_LONG_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic but,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press,
  output logic toggle
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic          accept;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  btn_state_t    state;

  assign s      = sync2 ^ ACTIVE_LOW;
  // A change is accepted on the last cycle of an unbroken disagreeing run.
  assign accept = (s != level) && (dcnt == D_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchroniser flops reset to the idle pin level, so a button held
      // through reset shows up as a fresh edge once rst falls.
      sync1      <= ACTIVE_LOW;
      sync2      <= ACTIVE_LOW;
      level      <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      toggle     <= 1'b0;
      dcnt       <= '0;
      hcnt       <= '0;
      state      <= ST_IDLE;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      sync1      <= but;
      sync2      <= sync1;
      press      <= accept && s;
      released   <= accept && !s;
      long_press <= 1'b0;

      if (s == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end

      if (accept && s) toggle <= ~toggle;

      // Release wins over a long-press landing on the same cycle.
      case (state)
        ST_IDLE: begin
          hcnt <= '0;
          if (accept && s) state <= ST_HELD;
        end
        ST_HELD: begin
          if (accept) begin
            state <= ST_IDLE;
            hcnt  <= '0;
          end else if (hcnt == H_LAST) begin
            long_press <= 1'b1;
            state      <= ST_LONG;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_LONG: begin
          if (accept) begin
            state <= ST_IDLE;
            hcnt  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          hcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_bank.sv
// N-channel push-button front end; each pin gets an independent button_channel.
// The release pulse is named `released` because `release` is a reserved word.
module button_bank
  import button_pkg::*;
#(
  parameter int N               = 2,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_100MHZ,
  parameter int LONG_CYCLES     = BTN_LONG_100MHZ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] but,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] long_press,
  output logic [N-1:0] toggle
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .but        (but[i]),
      .level      (level[i]),
      .press      (press[i]),
      .released   (released[i]),
      .long_press (long_press[i]),
      .toggle     (toggle[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: stimulus queues expected pulses with their
// cycle stamps, a negedge monitor pops and compares whenever a pulse appears.
module tb_button_bank;

  typedef enum int {K_PRESS = 0, K_RELEASE = 1, K_LONG = 2} kind_e;

  typedef struct {
    int    at;
    int    ch;
    kind_e kind;
    logic  lvl;
    logic  tog;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] but = 2'b00;
  logic [1:0] but_al = 2'b11;

  logic [1:0] level, press, released, long_press, toggle;
  logic [1:0] level_al, press_al, released_al, long_press_al, toggle_al;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t q0[$];
  ev_t q1[$];

  button_bank #(.N(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .but(but), .level(level), .press(press),
    .released(released), .long_press(long_press), .toggle(toggle)
  );

  button_bank #(.N(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut_al (
    .clk(clk), .rst(rst), .but(but_al), .level(level_al), .press(press_al),
    .released(released_al), .long_press(long_press_al), .toggle(toggle_al)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_ev(input int id, input int at, input int ch, input kind_e k,
                           input logic lvl, input logic tog);
    ev_t e;
    e.at = at; e.ch = ch; e.kind = k; e.lvl = lvl; e.tog = tog;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  function automatic int q_size(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_pop(input int id, output ev_t e);
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
  endtask

  function automatic ev_t q_front(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  task automatic monitor_dut(input int id, input logic [1:0] lv, input logic [1:0] pr,
                             input logic [1:0] rl, input logic [1:0] lp, input logic [1:0] tg);
    ev_t e;
    logic [2:0] pulses;
    // Anything stamped earlier than now was never seen.
    while (q_size(id) > 0 && q_front(id).at < cyc) begin
      q_pop(id, e);
      checks++;
      errors++;
      $display("FAIL missing_event dut%0d: ch%0d kind %0d expected at cycle %0d, not seen by %0d",
               id, e.ch, int'(e.kind), e.at, cyc);
    end
    for (int ch = 0; ch < 2; ch++) begin
      pulses = {lp[ch], rl[ch], pr[ch]};
      for (int k = 0; k < 3; k++) begin
        if (pulses[k]) begin
          if (q_size(id) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event dut%0d: ch%0d kind %0d at cycle %0d, expected none",
                     id, ch, k, cyc);
          end else begin
            q_pop(id, e);
            check($sformatf("event_cycle dut%0d", id), cyc, e.at);
            check($sformatf("event_ch dut%0d", id), ch, e.ch);
            check($sformatf("event_kind dut%0d", id), k, int'(e.kind));
            check($sformatf("event_level dut%0d ch%0d", id, ch), int'(lv[ch]), int'(e.lvl));
            check($sformatf("event_toggle dut%0d ch%0d", id, ch), int'(tg[ch]), int'(e.tog));
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_dut(0, level, press, released, long_press, toggle);
    monitor_dut(1, level_al, press_al, released_al, long_press_al, toggle_al);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    logic tog0, tog1;
    tog0 = 1'b0;
    tog1 = 1'b0;

    // Reset state
    wait_cycles(3);
    check("rst_level", int'(level), 0);
    check("rst_press", int'(press), 0);
    check("rst_released", int'(released), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_toggle", int'(toggle), 0);
    check("rst_al_level", int'(level_al), 0);
    check("rst_al_toggle", int'(toggle_al), 0);
    rst = 1'b0;
    wait_cycles(10);
    check("al_idle_high_level", int'(level_al), 0);

    // Clean short presses on ch0: press 6 cycles after the edge, release 6
    // cycles after the pin falls, toggle 1,0,1
    for (int k = 0; k < 3; k++) begin
      c = cyc;
      but[0] = 1'b1;
      tog0 = ~tog0;
      expect_ev(0, c + 6, 0, K_PRESS, 1'b1, tog0);
      wait_cycles(6);
      if (k == 0) begin
        check("clean_level0", int'(level[0]), 1);
        check("clean_level1_idle", int'(level[1]), 0);
        check("clean_toggle1_idle", int'(toggle[1]), 0);
      end
      but[0] = 1'b0;
      expect_ev(0, c + 12, 0, K_RELEASE, 1'b0, tog0);
      wait_cycles(14);
    end
    check("short_toggle_final", int'(toggle[0]), 1);

    // Bounce 1,1,1,0,1,... : the 0 restarts the window, press at c+10, then
    // held long enough for one long-press
    c = cyc;
    but[0] = 1'b1;
    wait_cycles(3);
    but[0] = 1'b0;
    wait_cycles(1);
    but[0] = 1'b1;
    tog0 = ~tog0;
    expect_ev(0, c + 10, 0, K_PRESS, 1'b1, tog0);
    expect_ev(0, c + 20, 0, K_LONG, 1'b1, tog0);
    wait_cycles(21);
    but[0] = 1'b0;
    expect_ev(0, c + 31, 0, K_RELEASE, 1'b0, tog0);
    wait_cycles(12);

    // Simultaneous long press on both channels, held 20 cycles past press
    c = cyc;
    but = 2'b11;
    tog0 = ~tog0;
    tog1 = ~tog1;
    expect_ev(0, c + 6, 0, K_PRESS, 1'b1, tog0);
    expect_ev(0, c + 6, 1, K_PRESS, 1'b1, tog1);
    expect_ev(0, c + 16, 0, K_LONG, 1'b1, tog0);
    expect_ev(0, c + 16, 1, K_LONG, 1'b1, tog1);
    wait_cycles(26);
    but = 2'b00;
    expect_ev(0, c + 32, 0, K_RELEASE, 1'b0, tog0);
    expect_ev(0, c + 32, 1, K_RELEASE, 1'b0, tog1);
    wait_cycles(12);

    // Reset at hold cycle 7 with the pin still high: no long-press, outputs
    // cleared, fresh press 6 cycles after rst drops
    c = cyc;
    but[0] = 1'b1;
    tog0 = ~tog0;
    expect_ev(0, c + 6, 0, K_PRESS, 1'b1, tog0);
    wait_cycles(13);
    rst = 1'b1;
    wait_cycles(1);
    check("midhold_rst_level", int'(level), 0);
    check("midhold_rst_toggle", int'(toggle), 0);
    check("midhold_rst_pulses", int'(press | released | long_press), 0);
    rst = 1'b0;
    tog0 = 1'b1;
    tog1 = 1'b0;
    expect_ev(0, c + 20, 0, K_PRESS, 1'b1, tog0);
    wait_cycles(6);
    but[0] = 1'b0;
    expect_ev(0, c + 26, 0, K_RELEASE, 1'b0, tog0);
    wait_cycles(12);

    // Active-low instance: pin 1->0 presses after 6 cycles
    c = cyc;
    but_al[1] = 1'b0;
    expect_ev(1, c + 6, 1, K_PRESS, 1'b1, 1'b1);
    wait_cycles(6);
    but_al[1] = 1'b1;
    expect_ev(1, c + 12, 1, K_RELEASE, 1'b0, 1'b1);
    wait_cycles(12);
    check("al_level0_idle", int'(level_al[0]), 0);

    wait_cycles(5);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
